// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the shared-memory-port arbiter, its two requesters and the memory.
// slave = arbiter side; master = requesters plus memory model.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_ack, if_rdata, if_stall,
        output dm_ack, dm_rdata, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_ack, if_rdata, if_stall,
        input  dm_ack, dm_rdata, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch and data access.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces fixed data-first priority with alternating grants.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
            $error("mem_port_arbiter: MEM_LATENCY must lie within 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_r;
    logic [3:0]          cnt_r;
    logic                mem_en_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                if_ack_r;
    logic                dm_ack_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   dm_rdata_r;
    logic                dm_pend_s;
    logic                if_pend_s;
    logic                grant_d_s;
    logic                grant_i_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;
    logic            last_grant_r;
`endif

    // Grant selection; a requester acked this cycle is masked so it cannot be re-granted
    always_comb begin
        dm_pend_s = bus.dm_req & ~dm_ack_r;
        if_pend_s = bus.if_req & ~if_ack_r;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (dm_pend_s && if_pend_s) begin
            grant_d_s = (last_grant_r == GRANT_FETCH);
        end else begin
            grant_d_s = dm_pend_s;
        end
`else
        grant_d_s = dm_pend_s;
`endif
        grant_i_s = if_pend_s & ~grant_d_s;
    end

    // Access sequencer: latches the winning request and holds the port until the count expires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            dm_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            if_ack_r <= 1'b0;
            dm_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        state_r     <= BUSY_D;
                        cnt_r       <= CNT_LOAD;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= bus.dm_we;
                        mem_addr_r  <= bus.dm_addr;
                        mem_wdata_r <= bus.dm_wdata;
                    end else if (grant_i_s) begin
                        state_r     <= BUSY_I;
                        cnt_r       <= CNT_LOAD;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= bus.if_addr;
                        mem_wdata_r <= {DATA_W{1'b0}};
                    end else begin
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (cnt_r == 4'd0) begin
                        // mem_rdata is only valid now, in the last busy cycle
                        if (state_r == BUSY_I) begin
                            if_rdata_r <= bus.mem_rdata;
                            if_ack_r   <= 1'b1;
                        end else begin
                            if (!mem_we_r) begin
                                dm_rdata_r <= bus.mem_rdata;
                            end else begin
                                dm_rdata_r <= dm_rdata_r;
                            end
                            dm_ack_r <= 1'b1;
                        end
                        state_r  <= IDLE;
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= 4'd0;
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers who won the last grant so a contested IDLE cycle favours the other side
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= GRANT_FETCH;
        end else if (state_r == IDLE && grant_d_s) begin
            last_grant_r <= GRANT_DATA;
        end else if (state_r == IDLE && grant_i_s) begin
            last_grant_r <= GRANT_FETCH;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_ack    = if_ack_r;
    assign bus.dm_ack    = dm_ack_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rdata  = dm_rdata_r;

    // Stalls must react in the request cycle itself, so they stay combinational
    assign bus.if_stall = bus.if_req & ~if_ack_r;
    assign bus.dm_stall = bus.dm_req & ~dm_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-schedule reference model.
// Build with MEM_ARB_ROUND_ROBIN_EN defined to exercise alternating arbitration.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LAT    = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one access record described by its grant cycle
    int          cyc;
    bit          m_act;
    int          m_start;
    bit          m_is_d;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_last_d;
    int          ack_i_cyc;
    int          ack_d_cyc;
    logic [31:0] m_if_rdata;
    logic [31:0] m_dm_rdata;
    logic [31:0] mem_arr [0:255];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic bit m_busy();
        return m_act && (cyc > m_start) && (cyc <= m_start + LAT);
    endfunction

    task automatic model_reset();
        m_act      = 1'b0;
        m_start    = -100;
        m_last_d   = 1'b0;
        ack_i_cyc  = -100;
        ack_d_cyc  = -100;
        m_if_rdata = 32'h0;
        m_dm_rdata = 32'h0;
    endtask

    task automatic compare();
        bit busy;
        bit ei;
        bit ed;
        busy = m_busy();
        ei   = (ack_i_cyc == cyc);
        ed   = (ack_d_cyc == cyc);
        chk("mem_en", bus.mem_en, busy);
        chk("mem_we", bus.mem_we, busy && m_we);
        if (busy) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            if (m_we) begin
                chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
        end
        chk("if_ack", bus.if_ack, ei);
        chk("dm_ack", bus.dm_ack, ed);
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("dm_rdata", bus.dm_rdata, m_dm_rdata);
        chk("if_stall", bus.if_stall, bus.if_req && !ei);
        chk("dm_stall", bus.dm_stall, bus.dm_req && !ed);
    endtask

    task automatic advance();
        bit dm_ok;
        bit if_ok;
        bit take_d;
        if (m_busy()) begin
            if (cyc == m_start + LAT) begin
                if (!m_is_d) begin
                    m_if_rdata = bus.mem_rdata;
                    ack_i_cyc  = cyc + 1;
                end else begin
                    if (m_we) mem_arr[m_addr[9:2]] = m_wdata;
                    else      m_dm_rdata = bus.mem_rdata;
                    ack_d_cyc = cyc + 1;
                end
                m_act = 1'b0;
            end
        end else begin
            dm_ok = bus.dm_req && (ack_d_cyc != cyc);
            if_ok = bus.if_req && (ack_i_cyc != cyc);
            if (dm_ok || if_ok) begin
                take_d   = dm_ok && (!if_ok || !RR || !m_last_d);
                m_act    = 1'b1;
                m_start  = cyc;
                m_is_d   = take_d;
                m_addr   = take_d ? bus.dm_addr : bus.if_addr;
                m_we     = take_d && bus.dm_we;
                m_wdata  = bus.dm_wdata;
                m_last_d = take_d;
            end
        end
    endtask

    task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                         input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        cyc++;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dm_req   = dr;
        bus.dm_we    = dwe;
        bus.dm_addr  = da;
        bus.dm_wdata = dd;
        if (m_act && cyc == m_start + LAT) bus.mem_rdata = mem_arr[m_addr[9:2]];
        else                               bus.mem_rdata = $urandom();
        @(negedge clk);
        compare();
        advance();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_en"},    bus.mem_en,    1'b0);
        chk({tag, "_mem_we"},    bus.mem_we,    1'b0);
        chk({tag, "_mem_addr"},  bus.mem_addr,  32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_if_ack"},    bus.if_ack,    1'b0);
        chk({tag, "_dm_ack"},    bus.dm_ack,    1'b0);
        chk({tag, "_if_rdata"},  bus.if_rdata,  32'h0);
        chk({tag, "_dm_rdata"},  bus.dm_rdata,  32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[8'h04] = 32'h0000_0013;
        mem_arr[8'h05] = 32'h00A0_0093;
        mem_arr[8'h06] = 32'h0010_0113;
        mem_arr[8'h08] = 32'h0020_0193;
        mem_arr[8'h80] = 32'h0000_0055;

        reset        = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'h0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 32'h0;
        bus.dm_wdata = 32'h0;
        bus.mem_rdata = 32'h0;
        model_reset();
        cyc = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Fetch only: held through its ack cycle, which must not re-grant
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
            if (i == 0) chk("lit_fetch_stall", bus.if_stall, 1'b1);
            if (i == 1) chk("lit_fetch_addr", bus.mem_addr, 32'h10);
            if (i == 3) chk("lit_fetch_ack", bus.if_ack, 1'b1);
            if (i == 3) chk("lit_fetch_rdata", bus.if_rdata, 32'h13);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_no_regrant", bus.mem_en, 1'b0);
        idle_cycles(1);

        // Store
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
            if (i == 2) chk("lit_store_we", bus.mem_we, 1'b1);
            if (i == 2) chk("lit_store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            if (i == 3) chk("lit_store_ack", bus.dm_ack, 1'b1);
            if (i == 3) chk("lit_store_rdata", bus.dm_rdata, 32'h0);
        end
        idle_cycles(2);

        // Reset in the first busy cycle abandons the fetch
        cycle(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        bus.if_req = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
            if (i == 3) chk("lit_refetch_rdata", bus.if_rdata, 32'h0010_0113);
        end
        idle_cycles(1);

        // Simultaneous requests: data first, fetch granted in the dm_ack cycle
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 32'h14, (i < 4), 1'b0, 32'h200, 32'h0);
            if (i == 3) chk("lit_sim_dm_ack", bus.dm_ack, 1'b1);
            if (i == 3) chk("lit_sim_dm_rdata", bus.dm_rdata, 32'h55);
            if (i == 4) chk("lit_sim_fetch_addr", bus.mem_addr, 32'h14);
            if (i == 6) chk("lit_sim_if_ack", bus.if_ack, 1'b1);
            if (i == 6) chk("lit_sim_if_rdata", bus.if_rdata, 32'h00A0_0093);
        end
        idle_cycles(1);

        // Request dropped early still completes and acks
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
        idle_cycles(2);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_drop_ack", bus.dm_ack, 1'b1);
        idle_cycles(1);

        // Both continuously pending
        for (int i = 0; i < 15; i++) cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'h200, 32'h0);
        idle_cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single shared, fixed-latency memory port between instruction fetch and the writeback-stage data access of the 3-stage pipeline.
- Grants one requester at a time and holds address, write enable and write data stable for the full access.
- Returns read data with a one-cycle ack pulse.
- Produces per-requester stall signals that the datapath uses to freeze the PC and the fetch/execute registers.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MEM_LATENCY, 2, cycles the memory needs with mem_en held; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch read request, level, held until if_ack
if_addr  input  ADDR_W  fetch address (Pc_f)
if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  output  DATA_W  fetched instruction, registered
if_stall  output  1  if_req & ~if_ack (combinational)
dm_req  input  1  data request, level, held until dm_ack
dm_we  input  1  1 = write, 0 = read
dm_addr  input  ADDR_W  data address (ALU_result_w)
dm_wdata  input  DATA_W  store data
dm_ack  output  1  one-cycle pulse: data access complete
dm_rdata  output  DATA_W  load data, registered
dm_stall  output  1  dm_req & ~dm_ack (combinational)
mem_en  output  1  memory access active
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid in the last busy cycle

Behaviour:
- Reset (asynchronous, any time, including mid-access) forces all of the following:
  - state IDLE, counter 0;
  - mem_en, mem_we, if_ack, dm_ack = 0;
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0;
  - any in-flight access is abandoned and produces no ack.
- FSM states: IDLE, BUSY_I, BUSY_D. All memory outputs are registered.
- IDLE:
  - A requester whose ack is high in the current cycle is masked, which prevents a double grant before it drops req.
  - If unmasked dm_req: latch dm_addr, dm_we and dm_wdata; go to BUSY_D.
  - Else if unmasked if_req: latch if_addr with we = 0; go to BUSY_I.
  - On either grant, counter loads MEM_LATENCY-1 and mem_en = 1 from the next cycle.
  - Default priority is data over fetch, because the data access belongs to the older instruction.
- BUSY_x:
  - mem_en = 1; mem_addr, mem_we and mem_wdata stay constant.
  - Input changes on requester ports are ignored.
  - Counter decrements each cycle.
  - When counter = 0:
    - sample mem_rdata into the granted rdata register (reads only);
    - pulse the granted ack for the next cycle;
    - return to IDLE with mem_en = 0, mem_we = 0.
- Latency: req is seen in IDLE at cycle T, ack is high at cycle T+1+MEM_LATENCY. With the default, a req seen at cycle 0 gives busy cycles 1–2 and ack in cycle 3.
- Back-to-back accesses:
  - The ack cycle is itself an IDLE cycle and may grant the other requester.
  - Minimum spacing between grants is MEM_LATENCY+1 cycles.
- Writes:
  - dm_ack pulses as for reads.
  - dm_rdata is left unchanged.
- rdata registers hold their value until the next completed read for the same requester.
- Simultaneous if_req and dm_req in IDLE: data is served first; fetch is granted in the dm_ack cycle.
- A req dropped before ack (e.g. on a flush) does not cancel the access. The access completes, the ack still pulses, and the requester ignores it.
- MEM_LATENCY outside 1..15: elaboration-time error.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - adds a 1-bit last_grant register, reset to fetch;
  - when both requests are pending in IDLE, grant the requester not granted last;
  - a single pending request is always granted.
- Undefined: fixed data-over-fetch priority; no last_grant register.

Test Plan:
- Reset, then fetch only: if_req = 1, if_addr = 0x0000_0010, mem_rdata = 0x0000_0013 in the last busy cycle -> mem_en high in cycles 1–2 with mem_addr 0x10; if_ack in cycle 3; if_rdata = 0x13; if_stall = 1 in cycles 0–2.
- Store: dm_req = 1, dm_we = 1, dm_addr = 0x100, dm_wdata = 0xDEAD_BEEF -> mem_we = 1 and mem_wdata constant for 2 cycles; dm_ack in cycle 3; dm_rdata unchanged.
- Simultaneous if_req and dm_req (load 0x200 returning 0x55, fetch 0x14) -> data served first; dm_ack in cycle 3; fetch granted in cycle 3; if_ack in cycle 6.
- Requests held one cycle after ack -> no second grant to the same requester; mem_en stays 0 when nothing else is pending.
- Reset asserted in the first busy cycle -> all outputs 0 immediately; no ack follows; a fresh if_req completes normally.
- MEM_ARB_ROUND_ROBIN_EN defined, both requesters continuously pending -> grants alternate D, I, D, I; acks every 3 cycles.
